// File: rtl/sigmoid_backward.sv
// Sigmoid backward pass: grad_out = grad_in * y*(1-y), Q3.5 in/out, Q0.8 y.
// One shared 16-bit shift-add accumulator runs the two 8-step multiplies.
module sigmoid_backward (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] y_in,
  input  logic [7:0] grad_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] grad_out,
  output logic [7:0] deriv_out
);

  typedef enum logic [1:0] {
    IDLE,
    DERIV,
    SCALE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  y_q, g_q, d8_q, gout_q;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mcand;
  logic [2:0]  cnt_q;
  logic        mbit;
  logic        last;

  assign last = (cnt_q == 3'd7);

  // DERIV: y*(256-y); SCALE: sext(grad)*d8, exact modulo 2^16
  always_comb begin
    mcand = '0;
    mbit  = 1'b0;
    unique case (1'b1)
      (state_q == DERIV): begin
        mcand = {7'd0, 9'd256 - {1'b0, y_q}};
        mbit  = y_q[cnt_q];
      end
      (state_q == SCALE): begin
        mcand = {{8{g_q[7]}}, g_q};
        mbit  = d8_q[cnt_q];
      end
      default: ;
    endcase
    acc_d = mbit ? acc_q + (mcand << cnt_q) : acc_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid)  state_d = DERIV;
      DERIV: if (last)      state_d = SCALE;
      SCALE: if (last)      state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q    <= '0;
      g_q    <= '0;
      d8_q   <= '0;
      gout_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            y_q   <= y_in;
            g_q   <= grad_in;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        DERIV: begin
          cnt_q <= cnt_q + 3'd1;
          if (last) begin
            d8_q  <= acc_d[15:8];
            acc_q <= '0;
          end else begin
            acc_q <= acc_d;
          end
        end
        SCALE: begin
          cnt_q <= cnt_q + 3'd1;
          acc_q <= acc_d;
          // >>> 8 of the Q3.13 product: taking the high byte floors
          if (last) gout_q <= acc_d[15:8];
        end
        default: ;
      endcase
    end
  end

  assign deriv_out = d8_q;
  assign grad_out  = gout_q;

endmodule
